muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, operand/Hi/Lo width; only 16 is supported and verified.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-004 Port: start  input  1  request to begin an operation; accepted only in IDLE or DONE.
REQ-005 Port: op  input  2  operation code: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 Port: inA  input  16  multiplicand/dividend, sampled on the accept cycle.
REQ-007 Port: inB  input  16  multiplier/divisor, sampled on the accept cycle.
REQ-008 Port: rd_hi  input  1  mfhi request.
REQ-009 Port: rd_lo  input  1  mflo request.
REQ-010 Port: busy  output  1  high in RUN and FIX.
REQ-011 Port: done  output  1  one-cycle pulse in DONE.
REQ-012 Port: div_zero  output  1  high with done when a div/divu had inB == 0.
REQ-013 Port: stall  output  1  pipeline hold request.
REQ-014 Port: result  output  16  mfhi/mflo read data.
REQ-015 Port: Hi, Lo  output  16 each  architectural Hi/Lo registers.

Function
REQ-016 FSM states SHALL be IDLE, RUN, FIX, DONE; the state register and Hi/Lo SHALL be the only architectural state, plus internal datapath registers.
REQ-017 On accept (start=1 in IDLE or DONE), the block SHALL latch op, the sign flags and the operand magnitudes, clear the iteration counter and enter RUN; signed ops use magnitudes, unsigned ops use raw operands.
REQ-018 RUN SHALL last exactly 16 cycles: one shift-add step per cycle for multiply, one restoring shift-subtract step per cycle for divide; a 5-bit counter counts 0..15.
REQ-019 After RUN, FIX SHALL last 1 cycle and apply sign correction: product negated if the signs differ (mult); quotient negated if the signs differ and remainder given the dividend's sign (div).
REQ-020 FIX->DONE SHALL load Hi/Lo: mult Hi=product[31:16], Lo=product[15:0]; div Lo=quotient, Hi=remainder.
REQ-021 Latency: accept at cycle t -> done=1 and new Hi/Lo visible at cycle t+18.
REQ-022 DONE SHALL return to IDLE after 1 cycle unless start=1, in which case the new op is accepted (back-to-back).
REQ-023 start while busy=1 SHALL be ignored, with no effect on state or operands.
REQ-024 div/divu with inB==0 SHALL go from accept directly to DONE (done at t+1) with div_zero=1 and Hi/Lo unchanged.
REQ-025 Signed -32768 / -1 SHALL give Lo=0x8000 and Hi=0x0000 with no error flag.
REQ-026 result SHALL be combinational: Hi if rd_hi, else Lo if rd_lo, else 0; rd_hi has priority when both are set.
REQ-027 stall SHALL equal (rd_hi|rd_lo) & busy; in DONE, reads return the new Hi/Lo without stall.
REQ-028 Hi/Lo SHALL change only on the DONE-entry edge or on reset.

Reset
REQ-029 reset=1 SHALL, at the next edge, force IDLE, Hi=Lo=0, counter=0, and busy=done=div_zero=stall=0.
REQ-030 Reset mid-operation SHALL discard the in-flight op; no done pulse follows.
REQ-031 Reset SHALL take priority over start at the same edge.

Verification
REQ-032 multu inA=300, inB=300 at t -> done at t+18, Hi=0x0001, Lo=0x5F90.
REQ-033 mult inA=0xFFFD (-3), inB=5 -> Hi=0xFFFF, Lo=0xFFF1; div inA=0xFFF9 (-7), inB=2 -> Lo=0xFFFD, Hi=0xFFFF.
REQ-034 divu inA=7, inB=0 at t -> done=1 and div_zero=1 at t+1; Hi/Lo keep prior values.
REQ-035 rd_lo=1 held from t+2 -> stall=1 through t+17, stall=0 at t+18 with result=new Lo; start pulse at t+5 ignored.
REQ-036 reset at t+8 of a mult -> IDLE at t+9 with Hi=Lo=0 and busy=0; no done through t+30.
REQ-037 div inA=0x8000, inB=0xFFFF, then start again in the DONE cycle -> Lo=0x8000, Hi=0; the second op's done arrives 18 cycles after the DONE cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative 16-cycle multiply/divide unit with MIPS-style Hi/Lo registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add / shift-subtract step per cycle, counter 0..15
// FIX   | sign correction, Hi/Lo loaded on exit
// DONE  | one-cycle done pulse; may accept a new op
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic                 sgn, accept;
  logic [WIDTH-1:0]     mag_a, mag_b, add_b;
  logic [WIDTH:0]       add_sum, rsh, diff;
  logic [2*WIDTH-1:0]   fix_prod;
  logic [WIDTH-1:0]     fix_quo, fix_rem;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = 1'b0;

    sgn    = ~op[0];
    accept = start && (state_q == S_IDLE || state_q == S_DONE);
    mag_a  = (sgn && inA[WIDTH-1]) ? -inA : inA;
    mag_b  = (sgn && inB[WIDTH-1]) ? -inB : inB;

    add_b   = acc_q[0] ? b_q : '0;
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, add_b};
    // Partial remainder shifted left by one; can exceed WIDTH bits before subtract.
    rsh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rsh - {1'b0, b_q};

    fix_prod = neg_q  ? -acc_q : acc_q;
    fix_quo  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          is_div_d = op[1];
          neg_d    = sgn && (inA[WIDTH-1] ^ inB[WIDTH-1]);
          rneg_d   = sgn && inA[WIDTH-1];
          cnt_d    = '0;
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            b_d   = mag_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            b_d   = mag_a;
          end
          if (op[1] && inB == '0) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!diff[WIDTH])
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH-1))
          state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div_q) begin
          hi_d = fix_rem;
          lo_d = fix_quo;
        end else begin
          hi_d = fix_prod[2*WIDTH-1:WIDTH];
          lo_d = fix_prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign stall    = (rd_hi | rd_lo) & busy_q;
  assign result   = rd_hi ? hi_q : (rd_lo ? lo_q : '0);
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, timing
// corner sequences, and random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, rd_hi, rd_lo;
  logic [1:0]  op;
  logic [15:0] inA, inB;
  logic        busy, done, div_zero, stall;
  logic [15:0] result, Hi, Lo;

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .busy(busy), .done(done), .div_zero(div_zero),
    .stall(stall), .result(result), .Hi(Hi), .Lo(Lo)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [15:0] mh = 16'h0, ml = 16'h0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, eh, el;
    logic        edz;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  function automatic void ref_op(input logic [1:0] o, input logic [15:0] a, b,
                                 input logic [15:0] ph, pl,
                                 output logic [15:0] eh, el, output logic edz);
    longint p;
    int sa, sb;
    logic [31:0] p32;
    eh = ph; el = pl; edz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: begin p = longint'(sa) * longint'(sb); p32 = p[31:0]; eh = p32[31:16]; el = p32[15:0]; end
      2'd1: begin p = longint'(a) * longint'(b);   p32 = p[31:0]; eh = p32[31:16]; el = p32[15:0]; end
      2'd2: if (b == 16'h0) edz = 1'b1; else begin el = 16'(sa / sb); eh = 16'(sa % sb); end
      default: if (b == 16'h0) edz = 1'b1; else begin el = a / b; eh = a % b; end
    endcase
  endfunction

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      step;
      n++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] a, b, input string nm);
    logic [15:0] eh, el;
    logic edz;
    int n;
    bit hold_ok;
    ref_op(o, a, b, mh, ml, eh, el, edz);
    op = o; inA = a; inB = b; start = 1'b1;
    step;
    start = 1'b0; op = 2'($urandom); inA = 16'($urandom); inB = 16'($urandom);
    n = 1; hold_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (Hi !== mh || Lo !== ml) hold_ok = 1'b0;
      step;
      n++;
    end
    check($sformatf("%s latency", nm), n, edz ? 1 : 18);
    check($sformatf("%s hilo_hold", nm), {31'd0, hold_ok}, 32'd1);
    check($sformatf("%s Hi", nm), Hi, eh);
    check($sformatf("%s Lo", nm), Lo, el);
    check($sformatf("%s div_zero", nm), div_zero, edz);
    mh = eh; ml = el;
    step;
    check($sformatf("%s done_drop", nm), done, 1'b0);
  endtask

  initial begin
    int n;
    bit sflag, dflag;
    logic [15:0] ra, rb;
    reset = 1'b1; start = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0;
    op = 2'd0; inA = 16'h0; inB = 16'h0;

    vt[0] = '{2'd1, 16'd300,  16'd300,  16'h0001, 16'h5F90, 1'b0};
    vt[1] = '{2'd3, 16'd7,    16'd0,    16'h0001, 16'h5F90, 1'b1};
    vt[2] = '{2'd0, 16'hFFFD, 16'd5,    16'hFFFF, 16'hFFF1, 1'b0};
    vt[3] = '{2'd2, 16'hFFF9, 16'd2,    16'hFFFF, 16'hFFFD, 1'b0};
    vt[4] = '{2'd2, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
    vt[5] = '{2'd0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
    vt[6] = '{2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vt[7] = '{2'd2, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
    vt[8] = '{2'd3, 16'hFFFF, 16'h0003, 16'h0000, 16'h5555, 1'b0};
    vt[9] = '{2'd2, 16'h1234, 16'h0000, 16'h0000, 16'h5555, 1'b1};

    step; step;
    reset = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst div_zero", div_zero, 1'b0);
    check("rst stall", stall, 1'b0);
    check("rst Hi", Hi, 16'h0);
    check("rst Lo", Lo, 16'h0);

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_Hi", i), Hi, vt[i].eh);
      check($sformatf("vec%0d tbl_Lo", i), Lo, vt[i].el);
    end

    // Reads in IDLE: no stall, rd_hi has priority.
    rd_hi = 1'b1; rd_lo = 1'b1; #1;
    check("idle stall", stall, 1'b0);
    check("idle rd_hi prio", result, 16'h0000);
    rd_hi = 1'b0; #1;
    check("idle rd_lo", result, 16'h5555);
    rd_lo = 1'b0; #1;
    check("idle no rd", result, 16'h0000);

    // Stall window with rd_lo held, and a start pulse ignored while busy.
    op = 2'd0; inA = 16'hFFFD; inB = 16'd5; start = 1'b1;
    step;
    start = 1'b0;
    check("stall t1 busy", busy, 1'b1);
    check("stall t1 stall", stall, 1'b0);
    sflag = 1'b1; dflag = 1'b1;
    for (int c = 2; c <= 17; c++) begin
      step;
      if (c == 2) rd_lo = 1'b1;
      if (c == 5) begin start = 1'b1; op = 2'd3; inA = 16'd7; inB = 16'd0; end
      if (c == 6) start = 1'b0;
      #1;
      if (stall !== 1'b1) sflag = 1'b0;
      if (done !== 1'b0) dflag = 1'b0;
    end
    check("stall held", {31'd0, sflag}, 32'd1);
    check("stall no early done", {31'd0, dflag}, 32'd1);
    step;
    check("stall t18 done", done, 1'b1);
    check("stall t18 stall", stall, 1'b0);
    check("stall t18 result", result, 16'hFFF1);
    check("stall t18 div_zero", div_zero, 1'b0);
    rd_hi = 1'b1; #1;
    check("done rd_hi", result, 16'hFFFF);
    rd_hi = 1'b0; rd_lo = 1'b0;
    step;
    check("stall after idle", busy, 1'b0);
    mh = 16'hFFFF; ml = 16'hFFF1;

    // Reset mid-operation.
    op = 2'd0; inA = 16'h1234; inB = 16'h5678; start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 2; c <= 8; c++) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst Hi", Hi, 16'h0);
    check("midrst Lo", Lo, 16'h0);
    check("midrst done", done, 1'b0);
    dflag = 1'b1;
    for (int c = 10; c <= 30; c++) begin
      step;
      if (done !== 1'b0 || busy !== 1'b0) dflag = 1'b0;
    end
    check("midrst no done", {31'd0, dflag}, 32'd1);
    mh = 16'h0; ml = 16'h0;

    // Reset beats start at the same edge.
    reset = 1'b1; start = 1'b1; op = 2'd1; inA = 16'd3; inB = 16'd3;
    step;
    reset = 1'b0; start = 1'b0;
    check("rst_prio busy", busy, 1'b0);
    step;
    check("rst_prio busy2", busy, 1'b0);

    // Overflow case followed by a back-to-back accept in the DONE cycle.
    op = 2'd2; inA = 16'h8000; inB = 16'hFFFF; start = 1'b1;
    step;
    start = 1'b0;
    wait_done(n);
    check("b2b first latency", n, 18);
    check("b2b first Lo", Lo, 16'h8000);
    check("b2b first Hi", Hi, 16'h0000);
    check("b2b first div_zero", div_zero, 1'b0);
    op = 2'd1; inA = 16'd300; inB = 16'd300; start = 1'b1;
    step;
    start = 1'b0;
    check("b2b busy", busy, 1'b1);
    wait_done(n);
    check("b2b second latency", n, 18);
    check("b2b second Hi", Hi, 16'h0001);
    check("b2b second Lo", Lo, 16'h5F90);
    step;
    mh = 16'h0001; ml = 16'h5F90;

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: rb = 16'hFFFF;
        2: ra = 16'h8000;
        default: ;
      endcase
      run_op(2'($urandom), ra, rb, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
